// File: rtl/conv_ofmap_reader_pkg.sv
// Shared sizing and state encoding for the ofmap reader and its row/col counter.
package conv_ofmap_reader_pkg;

  localparam int DATA_WIDTH        = 8;
  localparam int CONV_OFMAP_SIZE   = 4;
  localparam int CONV_COUNTER_SIZE = (CONV_OFMAP_SIZE > 1) ? $clog2(CONV_OFMAP_SIZE) : 1;
  localparam int OFMAP_PIXELS      = CONV_OFMAP_SIZE * CONV_OFMAP_SIZE;

  typedef enum logic [2:0] {
    READER_IDLE,
    READER_RUN,
    READER_RELEASE,
    READER_STREAM,
    READER_DONE
  } reader_state_t;

endpackage

// File: rtl/ofmap_rc_counter.sv
// Row-major row/col walker over a SIZE x SIZE map; wraps fully back to (0,0)
// after the last pixel so it can be shared with the pooling stage.
module ofmap_rc_counter
  import conv_ofmap_reader_pkg::*;
#(
  parameter int SIZE = CONV_OFMAP_SIZE,
  parameter int W    = CONV_COUNTER_SIZE
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         is_last
);

  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;
  logic         col_at_end;
  logic         row_at_end;

  assign col_at_end = (32'(col_q) == SIZE - 1);
  assign row_at_end = (32'(row_q) == SIZE - 1);
  assign is_last    = col_at_end && row_at_end;
  assign row        = row_q;
  assign col        = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_at_end) begin
        col_d = '0;
        row_d = row_at_end ? '0 : row_q + W'(1);
      end else begin
        col_d = col_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/conv_ofmap_reader.sv
// Runs the conv engine for one frame, snapshots its ofmap into flops, re-arms
// the engine, then streams the snapshot row-major over a valid/ready port.
module conv_ofmap_reader
  import conv_ofmap_reader_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int S  = CONV_OFMAP_SIZE,
  parameter int CW = CONV_COUNTER_SIZE
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          conv_en,
  output logic          conv_rst,
  input  logic          conv_done,
  input  logic [DW-1:0] conv_ofmap [S][S],
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] m_row,
  output logic [CW-1:0] m_col,
  output logic          m_last,
  output logic          busy,
  output logic          frame_done
);

  reader_state_t state_q, state_d;
  logic [DW-1:0] buf_q [S][S];
  logic [DW-1:0] buf_d [S][S];
  logic [CW-1:0] row, col;
  logic          is_last;
  logic          handshake;
  logic          capture;

  assign handshake = m_valid && m_ready;
  assign capture   = (state_q == READER_RUN) && conv_done;

  ofmap_rc_counter #(.SIZE(S), .W(CW)) u_rc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == READER_RELEASE),
    .en      (handshake),
    .row     (row),
    .col     (col),
    .is_last (is_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      READER_IDLE:    if (start) state_d = READER_RUN;
      READER_RUN:     if (conv_done) state_d = READER_RELEASE;
      READER_RELEASE: state_d = READER_STREAM;
      READER_STREAM:  if (handshake && is_last) state_d = READER_DONE;
      READER_DONE:    state_d = READER_IDLE;
      default:        state_d = READER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= READER_IDLE;
    else          state_q <= state_d;
  end

  // Snapshot storage carries no reset: its contents only matter after a capture.
  always_comb begin
    buf_d = buf_q;
    if (capture) buf_d = conv_ofmap;
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Every output is a decode of registered state/counters; stream fields are
  // forced to zero outside STREAM so idle outputs read as all-low.
  assign conv_en    = (state_q == READER_RUN);
  assign conv_rst   = (state_q == READER_RELEASE);
  assign m_valid    = (state_q == READER_STREAM);
  assign busy       = (state_q != READER_IDLE);
  assign frame_done = (state_q == READER_DONE);
  assign m_data     = m_valid ? buf_q[row][col] : '0;
  assign m_row      = m_valid ? row : '0;
  assign m_col      = m_valid ? col : '0;
  assign m_last     = m_valid && is_last;

endmodule

// File: tb/tb_conv_ofmap_reader.sv
// Directed + randomized bench for conv_ofmap_reader; expected stream is the
// captured ofmap walked row-major, derived from beat index arithmetic.
module tb_conv_ofmap_reader;
  import conv_ofmap_reader_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int S  = CONV_OFMAP_SIZE;
  localparam int CW = CONV_COUNTER_SIZE;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          conv_en;
  logic          conv_rst;
  logic          conv_done;
  logic [DW-1:0] conv_ofmap [S][S];
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_row;
  logic [CW-1:0] m_col;
  logic          m_last;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_pix [S][S];

  conv_ofmap_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .conv_en    (conv_en),
    .conv_rst   (conv_rst),
    .conv_done  (conv_done),
    .conv_ofmap (conv_ofmap),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row      (m_row),
    .m_col      (m_col),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic loadOfmap(input bit ramp);
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        exp_pix[r][c]    = ramp ? DW'(r * S + c) : DW'($urandom);
        conv_ofmap[r][c] = exp_pix[r][c];
      end
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = stall 5 cycles at beat 6.
  task automatic applyStimulus(input int latency, input int ready_mode, input bit overwrite,
                               input bit start_mid, input int abort_beat, input bit ramp);
    int beat;
    int budget;
    int stall;
    bit rdy;
    beat = 0;
    budget = 0;
    stall = 0;
    loadOfmap(ramp);
    if (latency == 0) conv_done = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("conv_en_after_start", conv_en, 1);
    checkOutput("busy_run", busy, 1);
    checkOutput("m_valid_run", m_valid, 0);
    if (latency > 0) begin
      for (int i = 1; i < latency; i++) begin
        tick();
        checkOutput("conv_en_hold", conv_en, 1);
        checkOutput("conv_rst_run", conv_rst, 0);
      end
      conv_done = 1'b1;
    end
    tick();
    checkOutput("conv_rst_release", conv_rst, 1);
    checkOutput("conv_en_release", conv_en, 0);
    checkOutput("m_valid_release", m_valid, 0);
    checkOutput("busy_release", busy, 1);
    conv_done = 1'b0;
    if (overwrite)
      for (int r = 0; r < S; r++)
        for (int c = 0; c < S; c++) conv_ofmap[r][c] = '1;
    tick();
    checkOutput("conv_rst_stream", conv_rst, 0);
    while (beat < S * S && budget < 1000) begin
      rdy = 1'b1;
      if (ready_mode == 1) rdy = ($urandom_range(0, 3) != 0);
      if (ready_mode == 2 && beat == 6 && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end
      m_ready = rdy;
      checkOutput("m_valid", m_valid, 1);
      checkOutput("m_data", m_data, exp_pix[beat / S][beat % S]);
      checkOutput("m_row", m_row, beat / S);
      checkOutput("m_col", m_col, beat % S);
      checkOutput("m_last", m_last, (beat == S * S - 1) ? 1 : 0);
      checkOutput("conv_en_stream", conv_en, 0);
      if (beat == abort_beat) begin
        reset_n = 1'b0;
        #1;
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_conv_en", conv_en, 0);
        checkOutput("rst_conv_rst", conv_rst, 0);
        checkOutput("rst_m_data", m_data, 0);
        m_ready = 1'b0;
        reset_n = 1'b1;
        return;
      end
      if (start_mid && beat == 3) start = 1'b1;
      tick();
      start = 1'b0;
      if (rdy) beat++;
      budget++;
    end
    checkOutput("stream_beats", beat, S * S);
    m_ready = 1'b0;
    checkOutput("frame_done_pulse", frame_done, 1);
    checkOutput("m_valid_done", m_valid, 0);
    checkOutput("busy_done", busy, 1);
    tick();
    checkOutput("frame_done_clear", frame_done, 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("conv_en_idle", conv_en, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    conv_done = 1'b0;
    m_ready   = 1'b0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) conv_ofmap[r][c] = '0;
    #12;
    checkOutput("reset_conv_en", conv_en, 0);
    checkOutput("reset_conv_rst", conv_rst, 0);
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_m_data", m_data, 0);
    checkOutput("reset_m_last", m_last, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    reset_n = 1'b1;
    tick();

    $display("[TB] basic ramp frame");
    applyStimulus(16, 0, 1'b0, 1'b0, -1, 1'b1);

    $display("[TB] backpressure at beat 6");
    applyStimulus(3, 2, 1'b0, 1'b0, -1, 1'b1);

    $display("[TB] ofmap overwritten after capture");
    applyStimulus(5, 1, 1'b1, 1'b0, -1, 1'b0);

    $display("[TB] start during stream is ignored");
    applyStimulus(2, 0, 1'b0, 1'b1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("no_second_frame_busy", busy, 0);
      checkOutput("no_second_frame_en", conv_en, 0);
    end

    $display("[TB] reset mid-stream at beat 9, then restart with conv_done pre-asserted");
    applyStimulus(4, 0, 1'b0, 1'b0, 9, 1'b1);
    tick();
    applyStimulus(0, 1, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] back-to-back frames");
    applyStimulus(1, 0, 1'b0, 1'b0, -1, 1'b0);
    applyStimulus(7, 1, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 4; f++)
      applyStimulus(int'($urandom_range(0, 12)), int'($urandom_range(0, 1)), 1'($urandom), 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
